// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and helpers for the parametrised register file.
//   rf_state_t : clear-sequencer states
//   clog2      : ceil(log2(v)), never less than 1, for sizing the clear pointer
package reg_file_pkg;

    typedef enum logic [0:0] {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// reg_file_param_if: write/read/clear bus of the register file.
//   WriteEn/WriteAddr/WriteData : single write port
//   ReadAddr/ReadData           : NUM_RD packed read ports, port p at [p*W +: W]
//   Clear                       : request to zero the whole array
//   InitBusy                    : high while the clear sequence runs
//   master modport drives requests, slave modport is the register file.
interface reg_file_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
);
    logic                       WriteEn;
    logic [ADDR_W-1:0]          WriteAddr;
    logic [DATA_W-1:0]          WriteData;
    logic [NUM_RD*ADDR_W-1:0]   ReadAddr;
    logic [NUM_RD*DATA_W-1:0]   ReadData;
    logic                       Clear;
    logic                       InitBusy;

    modport master (
        output WriteEn, WriteAddr, WriteData, ReadAddr, Clear,
        input  ReadData, InitBusy
    );

    modport slave (
        input  WriteEn, WriteAddr, WriteData, ReadAddr, Clear,
        output ReadData, InitBusy
    );
endinterface

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: clear sequencer for the register file.
//   Walks ClrPtr from 0 to DEPTH-1 after reset or a Clear request in READY,
//   emitting one zero-write per cycle.
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset (restarts the sweep at 0)
//   Clear    in  clear request, honoured only in READY
//   InitBusy out high while sweeping
//   ClrWe    out zero-write strobe for the array
//   ClrAddr  out address being zeroed
module rf_clear_seq
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned PTR_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Clear,
    output logic             InitBusy,
    output logic             ClrWe,
    output logic [PTR_W-1:0] ClrAddr
);
    localparam logic [PTR_W-1:0] LastPtr = PTR_W'(DEPTH - 1);

    rf_state_t        stateQ, stateD;
    logic [PTR_W-1:0] clrPtrQ, clrPtrD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= RF_INIT;
            clrPtrQ <= '0;
        end else begin
            stateQ  <= stateD;
            clrPtrQ <= clrPtrD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        clrPtrD = clrPtrQ;
        ClrWe   = 1'b0;
        unique case (stateQ)
            RF_INIT: begin
                // Clear requests here are ignored: the sweep is never restarted.
                ClrWe = 1'b1;
                if (clrPtrQ == LastPtr) begin
                    stateD  = RF_READY;
                    clrPtrD = '0;
                end else begin
                    clrPtrD = clrPtrQ + 1'b1;
                end
            end
            RF_READY: begin
                if (Clear) begin
                    stateD  = RF_INIT;
                    clrPtrD = '0;
                end
            end
            default: begin
                stateD  = RF_INIT;
                clrPtrD = '0;
            end
        endcase
    end

    assign InitBusy = (stateQ == RF_INIT);
    assign ClrAddr  = clrPtrQ;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised multi-read-port register file.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset; starts a full clear sweep
//   bus  slave modport of reg_file_param_if (write port, NUM_RD read ports,
//        Clear request, InitBusy status)
// The array has no reset; rf_clear_seq zeroes it one entry per cycle so it can
// map to distributed RAM. Reads are combinational and return 0 while busy.
// Optional feature: define RF_BYPASS_EN to forward a legal same-cycle write
// to any read port addressing it.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_param_if.slave bus
);
    localparam int unsigned PTR_W = clog2(DEPTH);

    logic             initBusy;
    logic             clrWe;
    logic [PTR_W-1:0] clrAddr;

    rf_clear_seq #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) uClearSeq (
        .clk      (clk),
        .rst      (rst),
        .Clear    (bus.Clear),
        .InitBusy (initBusy),
        .ClrWe    (clrWe),
        .ClrAddr  (clrAddr)
    );

    assign bus.InitBusy = initBusy;

    // Address maps to a real, writable/readable register.
    function automatic logic addrLegal(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    // User write survives only in READY, outside a Clear cycle, to a legal address.
    logic userWe;
    assign userWe = bus.WriteEn && !initBusy && !bus.Clear && addrLegal(bus.WriteAddr);

    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;

    always_comb begin
        memWe   = userWe;
        memAddr = bus.WriteAddr;
        memData = bus.WriteData;
        if (clrWe) begin
            memWe   = 1'b1;
            memAddr = ADDR_W'(clrAddr);
            memData = '0;
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
    end

    logic [NUM_RD*DATA_W-1:0] rdAll;

    always_comb begin
        rdAll = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (!initBusy && addrLegal(bus.ReadAddr[p*ADDR_W +: ADDR_W])) begin
                rdAll[p*DATA_W +: DATA_W] = mem[bus.ReadAddr[p*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
                if (userWe && (bus.ReadAddr[p*ADDR_W +: ADDR_W] == bus.WriteAddr)) begin
                    rdAll[p*DATA_W +: DATA_W] = bus.WriteData;
                end
`endif
            end
        end
    end

    assign bus.ReadData = rdAll;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a DEPTH=32/ZERO_REG=1 instance and a
// DEPTH=24/ZERO_REG=0 instance sharing clock and reset.
module tb_reg_file_param;
    import reg_file_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic clk;
    logic rst;

    reg_file_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();
    reg_file_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus24 ();

    reg_file_param #(
        .DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_file_param #(
        .DATA_W(32), .DEPTH(24), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b0)
    ) dut24 (
        .clk (clk),
        .rst (rst),
        .bus (bus24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rd0, rd1, rd24a, rd24b;
    assign rd0   = bus.ReadData[31:0];
    assign rd1   = bus.ReadData[63:32];
    assign rd24a = bus24.ReadData[31:0];
    assign rd24b = bus24.ReadData[63:32];

    int vecs;
    int miss;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t tbl[6];

    // Posedges until InitBusy of the main instance drops; 0 on timeout.
    task automatic waitReady(output int fall);
        fall = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) begin
                bus.Clear = 1'b0;
                chk("busy_rd_zero", rd0, 32'h0);
            end
            if (!bus.InitBusy) begin
                fall = c;
                break;
            end
        end
    endtask

    int fall;
    int fall24;

    initial begin
        vecs = 0;
        miss = 0;
        // r5 written in test 2, read back by vectors; r2 never written before vector 4.
        tbl[0] = '{1'b1, 5'd1,  32'h11111111, 5'd1,  5'd5,  32'h11111111, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd1,  32'hFFFFFFFF, 32'h11111111};
        tbl[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd31, 32'h00000000, 32'hFFFFFFFF};
        tbl[3] = '{1'b1, 5'd1,  32'h22222222, 5'd1,  5'd1,  32'h22222222, 32'h22222222};
        tbl[4] = '{1'b0, 5'd2,  32'h33333333, 5'd2,  5'd1,  32'h00000000, 32'h22222222};
        tbl[5] = '{1'b1, 5'd2,  32'h44444444, 5'd2,  5'd5,  32'h44444444, 32'hDEADBEEF};

        rst = 1'b1;
        bus.WriteEn = 1'b0;   bus.WriteAddr = '0;   bus.WriteData = '0;
        bus.ReadAddr = '0;    bus.Clear = 1'b0;
        bus24.WriteEn = 1'b0; bus24.WriteAddr = '0; bus24.WriteData = '0;
        bus24.ReadAddr = '0;  bus24.Clear = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.InitBusy), 32'h1);
        chk("rst_busy24", 32'(bus24.InitBusy), 32'h1);
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd1", rd1, 32'h0);

        // Test 1: clear length after reset release.
        @(negedge clk);
        rst = 1'b0;
        fall = 0;
        fall24 = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (!bus.InitBusy && fall == 0) fall = c;
            if (!bus24.InitBusy && fall24 == 0) fall24 = c;
            if (fall != 0 && fall24 != 0) break;
        end
        chk("init_len32", fall, 32);
        chk("init_len24", fall24, 24);

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.ReadAddr = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("zero_p0_r%0d", i), rd0, 32'h0);
            chk($sformatf("zero_p1_r%0d", 31 - i), rd1, 32'h0);
        end

        // Test 2: write r5, read on both ports.
        @(negedge clk);
        bus.WriteEn = 1'b1; bus.WriteAddr = 5'd5; bus.WriteData = 32'hDEADBEEF;
        bus.ReadAddr = {5'd5, 5'd5};
        #1;
        chk("r5_same_p0", rd0, Byp ? 32'hDEADBEEF : 32'h0);
        chk("r5_same_p1", rd1, Byp ? 32'hDEADBEEF : 32'h0);
        @(posedge clk);
        #1;
        chk("r5_next_p0", rd0, 32'hDEADBEEF);
        chk("r5_next_p1", rd1, 32'hDEADBEEF);

        // Test 3 (ZERO_REG=1): write to r0 neither stored nor forwarded.
        @(negedge clk);
        bus.WriteAddr = 5'd0; bus.WriteData = 32'h12345678;
        bus.ReadAddr = {5'd0, 5'd0};
        #1;
        chk("r0_zero_nofwd", rd0, 32'h0);

        // Table vectors.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.WriteEn = tbl[i].we; bus.WriteAddr = tbl[i].wa; bus.WriteData = tbl[i].wd;
            bus.ReadAddr = {tbl[i].ra1, tbl[i].ra0};
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_p0", i), rd0, tbl[i].exp0);
            chk($sformatf("tbl%0d_p1", i), rd1, tbl[i].exp1);
        end
        @(negedge clk);
        bus.WriteEn = 1'b0;

        // Tests 3/4 on DEPTH=24, ZERO_REG=0.
        bus24.WriteEn = 1'b1; bus24.WriteAddr = 5'd0; bus24.WriteData = 32'h12345678;
        bus24.ReadAddr = {5'd30, 5'd0};
        #1;
        chk("d24_r0_same", rd24a, Byp ? 32'h12345678 : 32'h0);
        @(posedge clk);
        #1;
        chk("d24_r0_next", rd24a, 32'h12345678);
        @(negedge clk);
        bus24.WriteAddr = 5'd30; bus24.WriteData = 32'hAAAAAAAA;
        bus24.ReadAddr = {5'd0, 5'd30};
        #1;
        chk("d24_a30_nofwd", rd24a, 32'h0);
        @(posedge clk);
        #1;
        chk("d24_a30_next", rd24a, 32'h0);
        chk("d24_r0_keep", rd24b, 32'h12345678);
        @(negedge clk);
        bus24.WriteAddr = 5'd23; bus24.WriteData = 32'hCAFEF00D;
        bus24.ReadAddr = {5'd23, 5'd23};
        @(posedge clk);
        #1;
        chk("d24_r23_p0", rd24a, 32'hCAFEF00D);
        chk("d24_r23_p1", rd24b, 32'hCAFEF00D);
        @(negedge clk);
        bus24.WriteEn = 1'b0;

        // Test 5: Clear beats a same-cycle write, INIT ignores writes and Clear.
        bus.WriteEn = 1'b1; bus.WriteAddr = 5'd7; bus.WriteData = 32'hA5A5A5A5;
        bus.ReadAddr = {5'd8, 5'd7};
        @(posedge clk);
        #1;
        chk("r7_written", rd0, 32'hA5A5A5A5);
        @(negedge clk);
        bus.Clear = 1'b1; bus.WriteAddr = 5'd8; bus.WriteData = 32'h88888888;
        #1;
        chk("clr_nofwd_r8", rd1, 32'h0);
        chk("clr_cycle_busy", 32'(bus.InitBusy), 32'h0);
        @(posedge clk);
        #1;
        chk("clr_busy", 32'(bus.InitBusy), 32'h1);
        // Keep writing r9 and holding Clear into INIT; both must be ignored.
        bus.WriteAddr = 5'd9; bus.WriteData = 32'h99999999;
        waitReady(fall);
        chk("clr_len", fall, 32);
        @(negedge clk);
        bus.WriteEn = 1'b0;
        bus.ReadAddr = {5'd8, 5'd7};
        #1;
        chk("clr_r7", rd0, 32'h0);
        chk("clr_r8", rd1, 32'h0);
        bus.ReadAddr = {5'd5, 5'd9};
        #1;
        chk("clr_r9", rd0, 32'h0);
        chk("clr_r5", rd1, 32'h0);

        // Test 6: reset during INIT restarts a full sweep.
        @(negedge clk);
        bus.WriteEn = 1'b1; bus.WriteAddr = 5'd20; bus.WriteData = 32'h20202020;
        bus.ReadAddr = {5'd20, 5'd20};
        @(posedge clk);
        #1;
        chk("r20_written", rd0, 32'h20202020);
        @(negedge clk);
        bus.WriteEn = 1'b0;
        bus.Clear = 1'b1;
        @(posedge clk);
        #1;
        bus.Clear = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(bus.InitBusy), 32'h1);
        chk("rst_mid_rd", rd0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitReady(fall);
        chk("rst_mid_len", fall, 32);
        @(negedge clk);
        #1;
        chk("rst_mid_r20", rd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
